// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the EX-stage ALU controller and its multiply/divide engine.
package alu_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SLL = 4'b0011,
        OP_XOR = 4'b0100,
        OP_SRL = 4'b0101,
        OP_SUB = 4'b0110,
        OP_BEQ = 4'b1000,
        OP_BNE = 4'b1001,
        OP_SRA = 4'b1010,
        OP_SLT = 4'b1100,
        OP_BGE = 4'b1101,
        OP_MD  = 4'b1111
    } alu_op_e;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } md_state_e;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    function automatic logic md_is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU) || (op == MD_REM) || (op == MD_REMU);
    endfunction

endpackage

// File: rtl/md_iter_core.sv
// Iterative sign-magnitude multiply/divide datapath: one shift-add or
// restoring-subtract step per step_i, sign fix and result load on finish_i.
module md_iter_core
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            step_i,
    input  logic            finish_i,
    input  logic            early_i,
    input  md_op_e          op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [XLEN-1:0] early_val_i,
    output logic [XLEN-1:0] result_o
);

    md_op_e          op_q;
    logic            neg_q;
    logic [XLEN-1:0] hi_q, lo_q, dvs_q, result_q;

    logic            a_neg, b_neg, neg_d;
    logic [XLEN-1:0] a_mag, b_mag;

    always_comb begin
        a_neg = a_i[XLEN-1] & (op_i inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
        b_neg = b_i[XLEN-1] & (op_i inside {MD_MUL, MD_MULH, MD_DIV, MD_REM});
        a_mag = a_neg ? -a_i : a_i;
        b_mag = b_neg ? -b_i : b_i;
        case (op_i)
            MD_REM, MD_REMU: neg_d = a_neg;
            // x/0 must yield all-ones regardless of the dividend sign
            MD_DIV, MD_DIVU: neg_d = (a_neg ^ b_neg) & (|b_i);
            default:         neg_d = a_neg ^ b_neg;
        endcase
    end

    logic [XLEN:0]     sum, r_sh;
    logic [XLEN-1:0]   diff, hi_n, lo_n, q_fix, r_fix, res_fix;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic              ge;

    always_comb begin
        sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
        r_sh = {hi_q, lo_q[XLEN-1]};
        ge   = r_sh >= {1'b0, dvs_q};
        diff = r_sh[XLEN-1:0] - dvs_q;
        if (md_is_div(op_q)) begin
            hi_n = ge ? diff : r_sh[XLEN-1:0];
            lo_n = {lo_q[XLEN-2:0], ge};
        end else begin
            hi_n = sum[XLEN:1];
            lo_n = {sum[0], lo_q[XLEN-1:1]};
        end
        prod     = {hi_n, lo_n};
        prod_fix = neg_q ? -prod : prod;
        q_fix    = neg_q ? -lo_n : lo_n;
        r_fix    = neg_q ? -hi_n : hi_n;
        case (op_q)
            MD_MUL:                      res_fix = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: res_fix = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:             res_fix = q_fix;
            default:                     res_fix = r_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= MD_MUL;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            dvs_q    <= '0;
            result_q <= '0;
        end else begin
            if (load_i) begin
                op_q  <= op_i;
                neg_q <= neg_d;
                hi_q  <= '0;
                lo_q  <= a_mag;
                dvs_q <= b_mag;
            end else if (step_i) begin
                hi_q <= hi_n;
                lo_q <= lo_n;
            end
            if (early_i)
                result_q <= early_val_i;
            else if (finish_i)
                result_q <= res_fix;
        end
    end

    assign result_o = result_q;

endmodule

// File: rtl/alu_md_controller.sv
// EX-stage ALU controller: Operation decode plus RV32M sequencing and stall.
// Optional early completion of trivial M ops under `MD_EARLY_OUT_EN.
module alu_md_controller
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      ALUOp,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    input  logic            ValidIn,
    input  logic            FlushIn,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic [3:0]      Operation,
    output logic            MdSel,
    output logic            Stall,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] MdResult
);

    logic    is_m, md_req;
    alu_op_e op_e;
    md_op_e  md_op;

    assign is_m   = (ALUOp == 2'b10) && (Funct7 == F7_MULDIV);
    assign md_req = ValidIn & is_m;
    assign md_op  = md_op_e'(Funct3);

    always_comb begin
        op_e = OP_AND;
        case (ALUOp)
            2'b00: op_e = OP_ADD;
            2'b01:
                case (Funct3)
                    3'b000:  op_e = OP_BEQ;
                    3'b001:  op_e = OP_BNE;
                    3'b100:  op_e = OP_SLT;
                    3'b101:  op_e = OP_BGE;
                    default: op_e = OP_AND;
                endcase
            2'b10:
                if (is_m) op_e = OP_MD;
                else
                    case (Funct3)
                        3'b000:  op_e = (Funct7 == F7_ALT) ? OP_SUB : OP_ADD;
                        3'b001:  op_e = OP_SLL;
                        3'b010:  op_e = OP_SLT;
                        3'b100:  op_e = OP_XOR;
                        3'b101:  op_e = (Funct7 == F7_ALT) ? OP_SRA : OP_SRL;
                        3'b110:  op_e = OP_OR;
                        default: op_e = OP_AND;
                    endcase
            default: op_e = OP_AND;
        endcase
    end

    assign Operation = op_e;
    assign MdSel     = is_m;

    logic            early_hit;
    logic [XLEN-1:0] early_val;

`ifdef MD_EARLY_OUT_EN
    always_comb begin
        early_hit = 1'b0;
        early_val = '0;
        if (md_is_div(md_op)) begin
            if (SrcB == '0) begin
                early_hit = 1'b1;
                early_val = (md_op inside {MD_DIV, MD_DIVU}) ? '1 : SrcA;
            end else if ((md_op inside {MD_DIV, MD_REM}) &&
                         SrcA == {1'b1, {(XLEN-1){1'b0}}} && SrcB == '1) begin
                early_hit = 1'b1;
                early_val = (md_op == MD_DIV) ? SrcA : '0;
            end
        end else if (SrcA == '0 || SrcB == '0) begin
            early_hit = 1'b1;
        end
    end
`else
    assign early_hit = 1'b0;
    assign early_val = '0;
`endif

    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q, busy_q;
    logic             start, step, last;

    assign start = (state_q == ST_IDLE) & md_req & ~FlushIn;
    assign step  = (state_q == ST_CALC) & ~FlushIn;
    assign last  = cnt_q == CNT_W'(XLEN - 1);

    // FlushIn overrides every state so a squashed M op never reports Done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (FlushIn) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE:
                        if (start) begin
                            busy_q <= 1'b1;
                            cnt_q  <= '0;
                            if (early_hit) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= ST_CALC;
                            end
                        end
                    ST_CALC: begin
                        cnt_q <= cnt_q + 1'b1;
                        if (last) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            cnt_q   <= '0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    md_iter_core #(.XLEN(XLEN)) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (start),
        .step_i     (step),
        .finish_i   (step & last),
        .early_i    (start & early_hit),
        .op_i       (md_op),
        .a_i        (SrcA),
        .b_i        (SrcB),
        .early_val_i(early_val),
        .result_o   (MdResult)
    );

    assign Done  = done_q;
    assign Busy  = busy_q;
    assign Stall = md_req & ~done_q & ~FlushIn;

endmodule

// File: tb/tb_alu_md_controller.sv
// Scoreboard bench: stimulus queues expected MdResult, a monitor checks it on Done.
module tb_alu_md_controller;

    localparam int XLEN = 32;
    localparam int FULL = XLEN + 1;
`ifdef MD_EARLY_OUT_EN
    localparam int SPEC = 1;
`else
    localparam int SPEC = FULL;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      ALUOp;
    logic [6:0]      Funct7;
    logic [2:0]      Funct3;
    logic            ValidIn, FlushIn;
    logic [XLEN-1:0] SrcA, SrcB;
    logic [3:0]      Operation;
    logic            MdSel, Stall, Busy, Done;
    logic [XLEN-1:0] MdResult;

    alu_md_controller #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3),
        .ValidIn(ValidIn), .FlushIn(FlushIn), .SrcA(SrcA), .SrcB(SrcB),
        .Operation(Operation), .MdSel(MdSel), .Stall(Stall), .Busy(Busy),
        .Done(Done), .MdResult(MdResult)
    );

    always #5 clk = ~clk;

    int              checks = 0;
    int              errors = 0;
    logic [XLEN-1:0] sb_q[$];
    logic [XLEN-1:0] last_exp = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && Done) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done got MdResult %h expected no Done", MdResult);
            end else begin
                logic [XLEN-1:0] e;
                e = sb_q.pop_front();
                if (MdResult !== e) begin
                    errors++;
                    $display("FAIL md_result got %h expected %h", MdResult, e);
                end
            end
        end
    end

    function automatic logic [3:0] exp_op(input logic [1:0] op, input logic [6:0] f7,
                                          input logic [2:0] f3);
        case (op)
            2'b00: return 4'b0010;
            2'b01:
                case (f3)
                    3'b000: return 4'b1000;
                    3'b001: return 4'b1001;
                    3'b100: return 4'b1100;
                    3'b101: return 4'b1101;
                    default: return 4'b0000;
                endcase
            2'b10:
                case (f3)
                    3'b000: return (f7 == 7'b0100000) ? 4'b0110 : 4'b0010;
                    3'b001: return 4'b0011;
                    3'b010: return 4'b1100;
                    3'b100: return 4'b0100;
                    3'b101: return (f7 == 7'b0100000) ? 4'b1010 : 4'b0101;
                    3'b110: return 4'b0001;
                    default: return 4'b0000;
                endcase
            default: return 4'b0000;
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1 after the DONE->IDLE edge.
    task automatic run_md(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_stall,
                          input bit wiggle);
        int st = 0;
        int cyc = 0;
        bit seen = 0;
        sb_q.push_back(exp);
        last_exp = exp;
        ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = f3;
        SrcA = a; SrcB = b; ValidIn = 1'b1;
        while (cyc < 200) begin
            @(negedge clk);
            if (Done) begin
                seen = 1;
                break;
            end
            if (Stall) st++;
            cyc++;
            if (wiggle && cyc == 5) begin
                SrcA = 32'h0BAD_F00D;
                SrcB = 32'h0000_0005;
            end
        end
        if (!seen) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout got no Done expected Done within 200 cycles", name);
            void'(sb_q.pop_back());
        end else begin
            check({name, "_stall_cycles"}, st, exp_stall);
            check({name, "_stall_at_done"}, Stall, 0);
        end
        @(posedge clk); #1;
        ValidIn = 1'b0;
        check({name, "_done_one_pulse"}, Done, 0);
    endtask

    initial begin
        rst_n = 1'b0; ALUOp = 2'b00; Funct7 = '0; Funct3 = '0;
        ValidIn = 1'b0; FlushIn = 1'b0; SrcA = '0; SrcB = '0;
        #12;
        check("reset_busy", Busy, 0);
        check("reset_done", Done, 0);
        check("reset_mdresult", MdResult, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Decode sweep, M group excluded
        ValidIn = 1'b1;
        for (int op = 0; op < 4; op++) begin
            for (int k = 0; k < 4; k++) begin
                logic [6:0] f7;
                case (k)
                    0: f7 = 7'b0000000;
                    1: f7 = 7'b0100000;
                    2: f7 = 7'b0000001;
                    default: f7 = 7'b1111111;
                endcase
                if (op == 2 && k == 2) continue;
                for (int f = 0; f < 8; f++) begin
                    ALUOp = op[1:0]; Funct7 = f7; Funct3 = f[2:0];
                    #1;
                    check($sformatf("decode_op_%0d_%h_%0d", op, f7, f), Operation,
                          exp_op(op[1:0], f7, f[2:0]));
                    check("decode_mdsel", MdSel, 0);
                    check("decode_stall", Stall, 0);
                end
            end
        end
        ValidIn = 1'b0;
        ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'b000;
        #1;
        check("m_operation", Operation, 4'b1111);
        check("m_mdsel", MdSel, 1);
        check("m_no_valid_stall", Stall, 0);
        @(posedge clk); #1;

        run_md("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, FULL, 0);
        check("busy_after_done", Busy, 0);
        run_md("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, FULL, 0);
        run_md("mulh",   3'b001, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, FULL, 0);
        run_md("div",    3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, FULL, 0);
        run_md("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, FULL, 0);
        run_md("divu",   3'b101, 32'd100,      32'd7,        32'd14,        FULL, 0);
        run_md("remu",   3'b111, 32'd100,      32'd7,        32'd2,         FULL, 0);
        run_md("div0",   3'b100, 32'h1234_5678, 32'd0,        32'hFFFF_FFFF, SPEC, 0);
        run_md("divneg0",3'b100, 32'hFFFF_FFF7, 32'd0,        32'hFFFF_FFFF, SPEC, 0);
        run_md("rem0",   3'b110, 32'd5,        32'd0,        32'd5,         SPEC, 0);
        run_md("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC, 0);
        run_md("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,       SPEC, 0);
        run_md("mulz",   3'b000, 32'd0,        32'd5,        32'h0,         SPEC, 0);

        // Flush at CALC cycle 10: no Done, MdResult retained
        run_md("preflush", 3'b101, 32'd90, 32'd4, 32'd22, FULL, 0);
        ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'b101;
        SrcA = 32'd1000; SrcB = 32'd3; ValidIn = 1'b1;
        repeat (11) @(posedge clk);
        #1 FlushIn = 1'b1;
        @(negedge clk);
        check("flush_stall", Stall, 0);
        check("flush_busy_before", Busy, 1);
        @(posedge clk); #1;
        FlushIn = 1'b0; ValidIn = 1'b0;
        @(negedge clk);
        check("flush_busy", Busy, 0);
        check("flush_done", Done, 0);
        check("flush_mdresult", MdResult, last_exp);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        run_md("divu_after_flush", 3'b101, 32'd100, 32'd7, 32'd14, FULL, 1);

        // Asynchronous reset mid-CALC
        ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'b000;
        SrcA = 32'd9; SrcB = 32'd9; ValidIn = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", Busy, 0);
        check("arst_done", Done, 0);
        check("arst_mdresult", MdResult, 0);
        ValidIn = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        run_md("b2b_mul", 3'b000, 32'hFFFF_FFFE, 32'hFFFF_FFFA, 32'd12,        FULL, 0);
        run_md("b2b_div", 3'b100, 32'd50,        32'hFFFF_FFF9, 32'hFFFF_FFF9, FULL, 0);

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
        if (sb_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
